jtcop_snd_post: RTL and testbench

- Post-processing stage directly downstream of the sound CPU subsystem.
- Consumes the mixed signed 16-bit sound and its sample strobe.
- Applies an optional DC-blocking high-pass, then a programmable gain with saturation, then a peak indicator with hold time.
- Output feeds the frame audio interface; runs at the 24 MHz system clock, one sample entering per strobe.

---
 rtl/jtcop_snd_pkg.sv | 28 ++
 rtl/jtcop_snd_dcblk.sv | 47 ++++
 rtl/jtcop_snd_post.sv | 111 +++++++++++
 tb/tb_jtcop_snd_post.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/jtcop_snd_pkg.sv
// rtl/jtcop_snd_pkg.sv - shared constants and saturation helper for the sound post-processing stage
package jtcop_snd_pkg;

    localparam int          DEF_K        = 8;
    localparam logic [15:0] DEF_PEAK_THR = 16'h7000;
    localparam logic [7:0]  UNITY_GAIN   = 8'h10;

    typedef struct packed {
        logic        sat;
        logic [15:0] val;
    } sat16_t;

    // Narrower sources (the 18-bit DC blocker sum) are sign-extended to 25 bits by the caller
    function automatic sat16_t sat16(input logic signed [24:0] v);
        sat16_t r;
        r.sat = 1'b1;
        if (v > 25'sd32767) begin
            r.val = 16'h7fff;
        end else if (v < -25'sd32768) begin
            r.val = 16'h8000;
        end else begin
            r.sat = 1'b0;
            r.val = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/jtcop_snd_dcblk.sv
// rtl/jtcop_snd_dcblk.sv - stage 1: optional first-order DC-blocking high-pass with x1/y1 history
module jtcop_snd_dcblk
    import jtcop_snd_pkg::*;
#(
    parameter int K = DEF_K
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        valid_i,
    input  logic        dc_en_i,
    input  logic [15:0] x_i,
    output logic        valid_o,
    output logic [15:0] y_o
);

    logic [15:0]        x1_q, y1_q, y_q;
    logic               valid_q;
    logic signed [17:0] t_w;
    logic [15:0]        y_d;

    always_comb begin
        t_w = 18'($signed(x_i)) - 18'($signed(x1_q))
            + 18'($signed(y1_q)) - 18'($signed(y1_q) >>> K);
        // Only the clamped value matters here; the clip flag is dropped by the size cast
        y_d = dc_en_i ? 16'(sat16(25'(t_w))) : x_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q    <= '0;
            y1_q    <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                x1_q <= x_i;
                y1_q <= dc_en_i ? y_d : 16'h0000;
                y_q  <= y_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign y_o     = y_q;

endmodule

// File: rtl/jtcop_snd_post.sv
// rtl/jtcop_snd_post.sv - sound post-processing: DC blocker, Q4.4 gain with saturation, peak hold
module jtcop_snd_post
    import jtcop_snd_pkg::*;
#(
    parameter int          K        = DEF_K,
    parameter logic [15:0] PEAK_THR = DEF_PEAK_THR,
    parameter int          HOLD_SMP = 1024,
    parameter int          HW       = 10
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        dc_en,
    input  logic [7:0]  gain,
    input  logic [15:0] snd_in,
    input  logic        sample_in,
    output logic [15:0] snd,
    output logic        sample,
    output logic        peak
);

    // Widen the hold counter if HW alone cannot represent HOLD_SMP
    localparam int             CW      = (HW > $clog2(HOLD_SMP + 1)) ? HW : $clog2(HOLD_SMP + 1);
    localparam logic [CW-1:0]  HOLD_LD = CW'(HOLD_SMP);

    logic               s1_valid;
    logic [15:0]        s1_y;

    logic signed [24:0] prod_w;
    sat16_t             gained_w;
    logic               s2_valid_q, s2_sat_q;
    logic [15:0]        s2_val_q;

    logic [16:0]        mag_w;
    logic               trig_w;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               peak_q, peak_d;
    logic [15:0]        snd_q, snd_d;
    logic               sample_q;

    jtcop_snd_dcblk #(.K(K)) u_dcblk (
        .rst     (rst),
        .clk     (clk),
        .valid_i (sample_in),
        .dc_en_i (dc_en),
        .x_i     (snd_in),
        .valid_o (s1_valid),
        .y_o     (s1_y)
    );

    always_comb begin
        prod_w   = 25'($signed(s1_y)) * 25'($signed({1'b0, gain}));
        gained_w = sat16(prod_w >>> 4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_val_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid;
            if (s1_valid) begin
                s2_sat_q <= gained_w.sat;
                s2_val_q <= gained_w.val;
            end
        end
    end

    // Two's-complement magnitude in 17 bits so that -32768 maps to 32768
    always_comb begin
        mag_w  = s2_val_q[15] ? (17'd0 - {s2_val_q[15], s2_val_q}) : {1'b0, s2_val_q};
        trig_w = s2_sat_q | (mag_w >= {1'b0, PEAK_THR});
    end

    always_comb begin
        cnt_d  = cnt_q;
        peak_d = peak_q;
        snd_d  = snd_q;
        if (s2_valid_q) begin
            snd_d = s2_val_q;
            if (trig_w) begin
                cnt_d  = HOLD_LD;
                peak_d = 1'b1;
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                peak_d = (cnt_d != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            peak_q   <= 1'b0;
            snd_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            snd_q    <= snd_d;
            sample_q <= s2_valid_q;
        end
    end

    assign snd    = snd_q;
    assign sample = sample_q;
    assign peak   = peak_q;

endmodule

// File: tb/tb_jtcop_snd_post.sv
// tb/tb_jtcop_snd_post.sv - directed scoreboard bench for jtcop_snd_post
module tb_jtcop_snd_post;
    import jtcop_snd_pkg::*;

    logic        rst, clk, dc_en, sample_in, sample, peak;
    logic [7:0]  gain;
    logic [15:0] snd_in, snd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] snd;
        logic        peak;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    jtcop_snd_post #(.HOLD_SMP(4), .HW(3)) dut (
        .rst       (rst),
        .clk       (clk),
        .dc_en     (dc_en),
        .gain      (gain),
        .snd_in    (snd_in),
        .sample_in (sample_in),
        .snd       (snd),
        .sample    (sample),
        .peak      (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] es, input logic ep);
        exp_t e;
        snd_in    = x;
        sample_in = 1'b1;
        e.snd     = es;
        e.peak    = ep;
        e.cyc     = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        sample_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sample === 1'b1) begin
            chk("expected_pulse", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("snd", $signed(snd), $signed(e.snd));
                chk("peak", peak, e.peak);
                chk("latency", cyc - e.cyc, 3);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_in = 1'b0; dc_en = 1'b0; gain = UNITY_GAIN; snd_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_snd", snd, 0);
        chk("rst_sample", sample, 0);
        chk("rst_peak", peak, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // DC blocker step response at unity gain
        dc_en = 1'b1; gain = 8'h10;
        send(16'd1000, 16'd1000, 1'b0);
        send(16'd1000, 16'd997,  1'b0);
        send(16'd1000, 16'd994,  1'b0);
        drain();

        // Bypass with clipping gain x2
        dc_en = 1'b0; gain = 8'h20;
        send(16'd20000,   16'h7fff, 1'b1);
        send(-16'sd20000, 16'h8000, 1'b1);
        drain();

        // Floor rounding at x0.5 and zero gain; hold counter runs down 3,2,1
        gain = 8'h08;
        send(16'd1001,   16'd500,   1'b1);
        send(-16'sd1001, -16'sd501, 1'b1);
        drain();
        gain = 8'h00;
        send(16'd1001, 16'd0, 1'b1);
        drain();

        // Peak hold of 4 samples, then retrigger on the 4th quiet slot
        gain = 8'h10;
        send(16'd32767, 16'd32767, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b0);
        send(16'd100, 16'd100, 1'b0);
        send(16'd32767, 16'd32767, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd30000, 16'd30000, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b1);
        send(16'd100, 16'd100, 1'b0);
        // Threshold boundary: 0x7000 triggers, one below does not
        send(16'd28671, 16'd28671, 1'b0);
        send(16'd28672, 16'd28672, 1'b1);

        // Back-to-back ramp, strobe every clock
        for (int i = 0; i < 8; i++) begin
            send(16'(i), 16'(i), (i < 3) ? 1'b1 : 1'b0);
        end
        drain();

        // Reset one clock after a strobe: in-flight sample is discarded
        snd_in = 16'd1234; sample_in = 1'b1;
        @(posedge clk); #1;
        sample_in = 1'b0; rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_no_pulse", sample, 0);
        end
        chk("rst_mid_snd", snd, 0);
        chk("rst_mid_peak", peak, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean history after reset, then stage-1 clamp at negative full scale
        dc_en = 1'b1; gain = 8'h10;
        send(16'd5000,    16'd5000,  1'b0);
        send(16'd5000,    16'd4981,  1'b0);
        send(-16'sd32768, 16'h8000,  1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
